// File: rtl/mips_mdu.sv
// rtl/mips_mdu.sv - multi-cycle multiply/divide unit with architectural HI/LO
// Optional accumulate ops (madd/maddu/msub) are built only when MIPS_MDU_MADD_EN is defined.
module mips_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  logic [31:0] hi_r, lo_r, p_hi, p_lo;
  logic [4:0]  cnt;
  logic        busy_r;
  logic        last, op_ok, accept, is_div;
  logic [63:0] base, prod_s, prod_u, res;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_abs, b_abs, quo_u, rem_u, quo, rem;

  assign last = busy_r && (cnt == 5'd1);
`ifdef MIPS_MDU_MADD_EN
  assign op_ok = (op != 3'd7);
`else
  assign op_ok = (op <= 3'd3);
`endif
  // A start landing on the commit edge is accepted, giving back-to-back ops.
  assign accept = start && op_ok && (!busy_r || last);
  assign is_div = (op == 3'd2) || (op == 3'd3);
  // Accumulate/hold base is whatever HI/LO will hold after this edge.
  assign base   = last ? {p_hi, p_lo} : {hi_r, lo_r};

  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Sign-magnitude division keeps 0x80000000 / -1 well defined.
  assign div_signed = (op == 3'd2);
  assign a_neg = div_signed & src_a[31];
  assign b_neg = div_signed & src_b[31];
  assign a_abs = a_neg ? -src_a : src_a;
  assign b_abs = (src_b == 32'd0) ? 32'd1 : (b_neg ? -src_b : src_b);
  assign quo_u = a_abs / b_abs;
  assign rem_u = a_abs % b_abs;
  assign quo   = (a_neg ^ b_neg) ? -quo_u : quo_u;
  assign rem   = a_neg ? -rem_u : rem_u;

  always_comb begin
    res = base;
    case (op)
      3'd0: res = prod_s;
      3'd1: res = prod_u;
      3'd2, 3'd3: if (src_b != 32'd0) res = {rem, quo};
`ifdef MIPS_MDU_MADD_EN
      3'd4: res = base + prod_s;
      3'd5: res = base + prod_u;
      3'd6: res = base - prod_s;
`endif
      default: res = base;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      cnt    <= 5'd0;
      busy_r <= 1'b0;
    end else begin
      if (last) begin
        hi_r <= p_hi;
        lo_r <= p_lo;
      end
      if (accept) begin
        p_hi   <= res[63:32];
        p_lo   <= res[31:0];
        cnt    <= is_div ? DIV_N : MULT_N;
        busy_r <= 1'b1;
      end else if (busy_r) begin
        cnt    <= last ? 5'd0 : cnt - 5'd1;
        busy_r <= !last;
      end else begin
        if (hi_we) hi_r <= src_a;
        if (lo_we) lo_r <= src_a;
      end
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
endmodule

// File: tb/tb_mips_mdu.sv
// tb/tb_mips_mdu.sv - self-checking bench for mips_mdu with a 64-bit arithmetic reference model
module tb_mips_mdu;
  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mips_mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int n_cycles(input logic [2:0] o);
    if (o <= 3'd1) return 5;
    if (o <= 3'd3) return 10;
`ifdef MIPS_MDU_MADD_EN
    if (o <= 3'd6) return 5;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
    longint sa, sb;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {h, l};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: if (b == 32'd0) return acc; else return {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 32'd0) return acc; else return {32'(ua % ub), 32'(ua / ub)};
      3'd4: return acc + 64'(sa * sb);
      3'd5: return acc + ua * ub;
      3'd6: return acc - 64'(sa * sb);
      default: return acc;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    int n;
    logic [63:0] e;
    n = n_cycles(o);
    e = (n > 0) ? ref_op(o, a, b, m_hi, m_lo) : {m_hi, m_lo};
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("hi_hold", hi, m_hi);
      chk("lo_hold", lo, m_lo);
      if (inject && i == 3) begin
        start = 1'b1; op = 3'd0; src_a = 32'h99; src_b = 32'd2; hi_we = 1'b1;
      end
      tick();
      start = 1'b0; hi_we = 1'b0;
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_res", hi, e[63:32]);
    chk("lo_res", lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt(input bit h, input logic [31:0] v);
    src_a = v; hi_we = h; lo_we = !h;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    if (h) m_hi = v; else m_lo = v;
    chk(h ? "mthi" : "mtlo", h ? hi : lo, v);
  endtask

  initial begin
    logic [2:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);

    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    run_op(3'd3, 32'd5, 32'd0, 1'b1);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // reset in cycle 3 of a running mult
    op = 3'd0; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("nocommit_busy", {31'd0, busy}, 32'd0);
      chk("nocommit_lo", lo, 32'd0);
    end

    // back-to-back multu 2x3 then 4x5
    op = 3'd1; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("b2b_busy1", {31'd0, busy}, 32'd1);
      if (i == 5) begin src_a = 32'd4; src_b = 32'd5; start = 1'b1; end
      tick();
      start = 1'b0;
    end
    chk("b2b_lo1", lo, 32'd6);
    chk("b2b_hi1", hi, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      chk("b2b_busy2", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("b2b_done", {31'd0, busy}, 32'd0);
    chk("b2b_lo2", lo, 32'd20);
    m_hi = 32'd0; m_lo = 32'd20;

    run_op(3'd7, 32'd1, 32'd2, 1'b0);

    mt(1'b1, 32'd0);
    mt(1'b0, 32'hFFFFFFFF);
    run_op(3'd5, 32'd1, 32'd1, 1'b0);
`ifdef MIPS_MDU_MADD_EN
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`else
    chk("maddu_off_hi", hi, 32'd0);
    chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    for (int k = 0; k < 20; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_mdu.md
# mips_mdu

Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. Sits in EX, directly downstream of the register file and forwarding muxes. It consumes the forwarded rs/rt operands, runs mult/div ops over a fixed cycle count and exposes HI/LO for mfhi/mflo. The hazard unit stalls the D stage on `start | busy` when an MDU instruction or mfhi/mflo is in D.

## Interface
- `MULT_CYCLES`, 5: busy duration of mult/multu/madd/maddu/msub; legal range 1..31.
- `DIV_CYCLES`, 10: busy duration of div/divu; legal range 1..31.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch the op on `op`, using `src_a` (rs) and `src_b` (rt).
- `op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 reserved.
- `src_a`  in  32  rs operand, already forwarded.
- `src_b`  in  32  rt operand, already forwarded.
- `hi_we`  in  1  mthi: HI <= `src_a`.
- `lo_we`  in  1  mtlo: LO <= `src_a`.
- `busy`  out  1  registered; high while an op is in flight.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- State: HI, LO, 5-bit countdown `cnt`, pending result `p_hi`/`p_lo`, `busy`.
- An accepted start computes the full result in the same cycle and latches it into `p_hi`/`p_lo`. It loads `cnt` with MULT_CYCLES or DIV_CYCLES and sets `busy`.
- While busy, `cnt` decrements each cycle. When `cnt` reaches 1, the next edge commits `p_hi`/`p_lo` to HI/LO, clears `busy` and sets `cnt` to 0.
- mult: {HI,LO} = signed 64-bit product of `src_a` and `src_b`.
- multu: {HI,LO} = unsigned 64-bit product of `src_a` and `src_b`.
- div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - Divisor 0: the op still runs DIV_CYCLES, then HI and LO stay unchanged.
- madd/maddu: {HI,LO} = {HI,LO} + product, modulo 2^64. The product is signed for madd, unsigned for maddu.
- msub: {HI,LO} = {HI,LO} − signed product, modulo 2^64.
- Accumulate ops sample HI/LO at start. No other write can intervene, because writes are blocked while busy.
- `op` = 7, or 4-6 with the feature compiled out: start is ignored; no busy, no state change.
- start while `busy`: ignored. The controller must not issue it; the bench checks that the unit tolerates it.
- `hi_we`/`lo_we` while `busy`: ignored.
- `hi_we`/`lo_we` when idle: take effect at that edge. Both may be asserted together.
- start together with `hi_we` or `lo_we` in the same cycle: start wins and the mt write is dropped.
- `hi`/`lo` show the committed values only; the old values are visible throughout busy.

## Timing
- Reset: HI = 0, LO = 0, `busy` = 0, `cnt` = 0, pending registers = 0. Reset mid-operation aborts the op and no commit occurs.
- Start accepted at edge E0: `busy` is 1 from after E0 through edge E_N, where N is the op's cycle count.
- Commit happens at edge E_N. `busy` reads 0 and `hi`/`lo` show the new values in the cycle after E_N.
- A new start is accepted at E_N, the same edge as the commit. Back-to-back ops have N cycles of busy and no gap cycle.
  - Example: N=5, start at E0 → `busy` high for cycles 1-5 → new `hi`/`lo` in cycle 6.
- mthi/mtlo latency: 1 edge.
- No combinational path from `start` to `busy`. The hazard unit ORs them itself.

## Configuration
- `MIPS_MDU_MADD_EN` defined: ops 4-6 (madd, maddu, msub) are implemented as above.
- `MIPS_MDU_MADD_EN` undefined: ops 4-6 behave like op 7 (ignored). No 64-bit adder/accumulator is synthesized.

## Test plan
- Reset, then mult 0xFFFFFFFE × 0x00000003 → `busy` high for 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. multu with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- div 0xFFFFFFF9 (−7) / 2 → `busy` high for 10 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- mthi 0x11, mtlo 0x22; then divu 5 / 0 → after 10 cycles HI = 0x11, LO = 0x22 (unchanged). A start and mthi 0x99 issued mid-busy are both ignored.
- mult 3 × 4 running; assert reset in cycle 3 → next cycle `busy` = 0, HI = LO = 0, and no commit appears afterwards.
- Back-to-back: start multu 2×3 at E0, then multu 4×5 at E5 → LO = 6 after E5, LO = 20 after E10; `busy` never drops between the ops.
- With `MIPS_MDU_MADD_EN`: HI/LO = 0/0xFFFFFFFF, then maddu 1×1 → HI = 1, LO = 0. Without the macro, the same stimulus → `busy` stays 0 and HI/LO are unchanged.
